// File: rtl/gecko_decode_scoreboard.sv
// gecko_decode_scoreboard
// In-flight write scoreboard for the gecko decode stage. Each architectural
// register (except x0) owns a small saturating counter of outstanding writes.
// Decode is allowed to issue when every used source is readable (idle, x0, or
// exactly one write in flight that execute forwards next cycle) and the
// destination counter still has headroom. Writeback retires entries through
// several ports per cycle.

module gecko_decode_scoreboard #(
    parameter int NUM_REGS         = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int COUNTER_WIDTH    = 2,
    parameter int NUM_READ_PORTS   = 2,
    parameter int NUM_RETIRE_PORTS = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       clear,
    input  logic                                       issue_valid,
    output logic                                       issue_ready,
    input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0]   issue_rs,
    input  logic [NUM_READ_PORTS-1:0]                  issue_rs_used,
    input  logic [REG_ADDR_WIDTH-1:0]                  issue_rd,
    input  logic                                       issue_rd_used,
    input  logic [REG_ADDR_WIDTH-1:0]                  fwd_reg,
    input  logic [NUM_RETIRE_PORTS-1:0]                retire_valid,
    input  logic [NUM_RETIRE_PORTS*REG_ADDR_WIDTH-1:0] retire_rd,
    output logic [NUM_REGS-1:0]                        busy_mask,
    output logic [REG_ADDR_WIDTH+COUNTER_WIDTH-1:0]    inflight_total,
    output logic                                       err_underflow,
    output logic                                       err_overflow
);

    localparam int TOTAL_WIDTH = REG_ADDR_WIDTH + COUNTER_WIDTH;
    localparam int CNT_MAX_INT = (1 << COUNTER_WIDTH) - 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    // Architectural state: per-register counters plus registered summaries.
    logic [COUNTER_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [COUNTER_WIDTH-1:0] cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busyMask_q;
    logic [NUM_REGS-1:0]      busyMask_d;
    logic [TOTAL_WIDTH-1:0]   inflightTotal_q;
    logic [TOTAL_WIDTH-1:0]   inflightTotal_d;
    logic                     errUnderflow_q;
    logic                     errOverflow_q;

    logic                      underflowHit;
    logic                      overflowHit;
    logic [NUM_READ_PORTS-1:0] srcOk;
    logic                      rdOk;
    logic                      fire;

    // A source blocks issue only while a write is pending that the execute
    // bypass cannot cover; the bypass covers exactly one outstanding write.
    for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_src
        logic [REG_ADDR_WIDTH-1:0] rsAddr;
        logic                      rsIdle;
        logic                      rsBypass;
        assign rsAddr   = issue_rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign rsIdle   = (rsAddr == '0) || (cnt_q[rsAddr] == '0);
        assign rsBypass = (rsAddr == fwd_reg) && (fwd_reg != '0) && (cnt_q[rsAddr] == CNT_ONE);
        assign srcOk[k] = !issue_rs_used[k] || rsIdle || rsBypass;
    end

    // The destination must leave room for one more outstanding write so the
    // counter can never wrap.
    assign rdOk = !issue_rd_used || (issue_rd == '0) || (cnt_q[issue_rd] != CNT_MAX);

    // Readiness looks at registered counters only, so retires this cycle do not
    // ripple into decode; it is forced low during reset and on a flush.
    assign issue_ready = rst_n && !clear && (&srcOk) && rdOk;
    assign fire        = issue_valid && issue_ready;

    // Net per-register update: one possible increment from issue, one
    // decrement per matching retire port, clamped at zero with error capture.
    always_comb begin : nextCount
        int level;
        int drops;
        underflowHit    = 1'b0;
        overflowHit     = 1'b0;
        busyMask_d      = '0;
        inflightTotal_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            level    = int'(cnt_q[r]);
            drops    = 0;
            if (r == 0) begin
                cnt_d[r] = '0;
            end else begin
                if (fire && issue_rd_used && (issue_rd == REG_ADDR_WIDTH'(r))) begin
                    level = level + 1;
                end
                for (int j = 0; j < NUM_RETIRE_PORTS; j++) begin
                    if (retire_valid[j] &&
                        (retire_rd[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == REG_ADDR_WIDTH'(r))) begin
                        drops = drops + 1;
                    end
                end
                level = level - drops;
                if (clear) begin
                    cnt_d[r] = '0;
                end else if (level < 0) begin
                    cnt_d[r]     = '0;
                    underflowHit = 1'b1;
                end else if (level > CNT_MAX_INT) begin
                    cnt_d[r]    = CNT_MAX;
                    overflowHit = 1'b1;
                end else begin
                    cnt_d[r] = COUNTER_WIDTH'(level);
                end
            end
            busyMask_d[r]   = (cnt_d[r] != '0);
            inflightTotal_d = inflightTotal_d + TOTAL_WIDTH'(cnt_d[r]);
        end
    end

    // Counters, summaries and sticky error flags; only rst_n clears the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            busyMask_q      <= '0;
            inflightTotal_q <= '0;
            errUnderflow_q  <= 1'b0;
            errOverflow_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busyMask_q      <= busyMask_d;
            inflightTotal_q <= inflightTotal_d;
            errUnderflow_q  <= errUnderflow_q | underflowHit;
            errOverflow_q   <= errOverflow_q | overflowHit;
        end
    end

    assign busy_mask      = busyMask_q;
    assign inflight_total = inflightTotal_q;
    assign err_underflow  = errUnderflow_q;
    assign err_overflow   = errOverflow_q;

endmodule

// File: tb/tb_gecko_decode_scoreboard.sv
// tb_gecko_decode_scoreboard
// Drives directed scenarios and random traffic into the scoreboard. A
// behavioural model of the per-register in-flight counts predicts readiness
// and the registered outputs; predictions are queued and a separate monitor
// compares them against the design each cycle.

module tb_gecko_decode_scoreboard;

    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int RP   = 2;
    localparam int WP   = 2;
    localparam int MAXC = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic            issue_valid;
    logic            issue_ready;
    logic [RP*AW-1:0] issue_rs;
    logic [RP-1:0]   issue_rs_used;
    logic [AW-1:0]   issue_rd;
    logic            issue_rd_used;
    logic [AW-1:0]   fwd_reg;
    logic [WP-1:0]   retire_valid;
    logic [WP*AW-1:0] retire_rd;
    logic [NR-1:0]   busy_mask;
    logic [AW+CW-1:0] inflight_total;
    logic            err_underflow;
    logic            err_overflow;

    typedef struct packed {
        logic        ready;
        logic [31:0] busy;
        logic [6:0]  total;
        logic        errU;
    } expT;

    expT expQ[$];
    int  mc[NR];
    bit  mErrU;
    int  totalChecks = 0;
    int  badChecks   = 0;

    gecko_decode_scoreboard #(
        .NUM_REGS(NR), .REG_ADDR_WIDTH(AW), .COUNTER_WIDTH(CW),
        .NUM_READ_PORTS(RP), .NUM_RETIRE_PORTS(WP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
        .issue_rd(issue_rd), .issue_rd_used(issue_rd_used),
        .fwd_reg(fwd_reg), .retire_valid(retire_valid), .retire_rd(retire_rd),
        .busy_mask(busy_mask), .inflight_total(inflight_total),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        totalChecks++;
        if (act !== req) begin
            badChecks++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit modelReadable(input int rs, input int fwd);
        return (rs == 0) || (mc[rs] == 0) || (rs == fwd && fwd != 0 && mc[rs] == 1);
    endfunction

    task automatic driveIdle();
        issue_valid   = 1'b0;
        issue_rs      = '0;
        issue_rs_used = '0;
        issue_rd      = '0;
        issue_rd_used = 1'b0;
        fwd_reg       = '0;
        retire_valid  = '0;
        retire_rd     = '0;
        clear         = 1'b0;
    endtask

    task automatic applyStimulus(input bit valid, input int rs1, input int rs2, input bit [1:0] rsUsed,
                                 input int rd, input bit rdUsed, input int fwd,
                                 input bit [1:0] retV, input int ret0, input int ret1, input bit clr);
        expT e;
        bit  rdy;
        int  delta;
        @(negedge clk);
        issue_valid   = valid;
        issue_rs      = {AW'(rs2), AW'(rs1)};
        issue_rs_used = rsUsed;
        issue_rd      = AW'(rd);
        issue_rd_used = rdUsed;
        fwd_reg       = AW'(fwd);
        retire_valid  = retV;
        retire_rd     = {AW'(ret1), AW'(ret0)};
        clear         = clr;
        rdy = !clr;
        if (rsUsed[0] && !modelReadable(rs1, fwd)) rdy = 1'b0;
        if (rsUsed[1] && !modelReadable(rs2, fwd)) rdy = 1'b0;
        if (rdUsed && rd != 0 && mc[rd] == MAXC) rdy = 1'b0;
        for (int r = 1; r < NR; r++) begin
            if (clr) begin
                mc[r] = 0;
            end else begin
                delta = 0;
                if (valid && rdy && rdUsed && rd == r) delta++;
                if (retV[0] && ret0 == r) delta--;
                if (retV[1] && ret1 == r) delta--;
                mc[r] = mc[r] + delta;
                if (mc[r] < 0) begin
                    mc[r] = 0;
                    mErrU = 1'b1;
                end
            end
        end
        e.ready = rdy;
        e.busy  = '0;
        e.total = '0;
        for (int r = 1; r < NR; r++) begin
            if (mc[r] != 0) e.busy[r] = 1'b1;
            e.total = e.total + 7'(mc[r]);
        end
        e.errU = mErrU;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        @(negedge clk);
        driveIdle();
        issue_rs      = {AW'(2), AW'(1)};
        issue_rs_used = 2'b11;
        rst_n         = 1'b0;
        for (int r = 0; r < NR; r++) mc[r] = 0;
        mErrU = 1'b0;
        #2;
        checkOutput("reset_issue_ready", 32'(issue_ready), 32'd0);
        checkOutput("reset_busy_mask", busy_mask, 32'd0);
        checkOutput("reset_inflight_total", 32'(inflight_total), 32'd0);
        checkOutput("reset_err_underflow", 32'(err_underflow), 32'd0);
        checkOutput("reset_err_overflow", 32'(err_overflow), 32'd0);
        @(negedge clk);
        driveIdle();
        rst_n = 1'b1;
    endtask

    // Monitor: pops one prediction per driven cycle, checks readiness before the
    // edge and the registered outputs just after it.
    initial begin : monitor
        expT e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("issue_ready", 32'(issue_ready), 32'(e.ready));
                @(posedge clk);
                #1;
                checkOutput("busy_mask", busy_mask, e.busy);
                checkOutput("inflight_total", 32'(inflight_total), 32'(e.total));
                checkOutput("err_underflow", 32'(err_underflow), 32'(e.errU));
                checkOutput("err_overflow", 32'(err_overflow), 32'd0);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by random traffic
    initial begin : stimulus
        driveIdle();
        rst_n = 1'b0;
        for (int r = 0; r < NR; r++) mc[r] = 0;
        mErrU = 1'b0;
        #2;
        checkOutput("por_issue_ready", 32'(issue_ready), 32'd0);
        checkOutput("por_busy_mask", busy_mask, 32'd0);
        checkOutput("por_inflight_total", 32'(inflight_total), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset release and first issue");
        applyStimulus(1, 1, 2, 2'b11, 3, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 3, 0, 0);

        $display("[TB] read-after-write stall");
        applyStimulus(1, 0, 0, 2'b00, 5, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 5, 0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 5, 0, 2'b01, 0, 0, 0, 2'b10, 0, 5, 0);
        applyStimulus(1, 5, 0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 0);

        $display("[TB] execute bypass");
        applyStimulus(1, 0, 0, 2'b00, 5, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 5, 0, 2'b01, 0, 0, 5, 2'b00, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 5, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 0, 5, 2'b10, 0, 0, 5, 2'b00, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b11, 5, 5, 0);

        $display("[TB] saturation");
        repeat (3) applyStimulus(1, 0, 0, 2'b00, 7, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 7, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b11, 7, 7, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 7, 0, 0);

        $display("[TB] simultaneous issue and retire");
        applyStimulus(1, 0, 0, 2'b00, 9, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 9, 1, 0, 2'b01, 9, 0, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b11, 9, 9, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b11, 0, 0, 0);

        $display("[TB] clear and x0");
        for (int r = 1; r <= 4; r++) applyStimulus(1, 0, 0, 2'b00, r, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 1, 1, 0, 2'b01, 2, 0, 1);
        applyStimulus(1, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0);

        $display("[TB] reset during operation");
        applyStimulus(1, 0, 0, 2'b00, 6, 1, 0, 2'b00, 0, 0, 0);
        doReset();

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) doReset();
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 1) != 0) ? $urandom_range(1, 7) : 0,
                          2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 63) == 0);
        end

        @(negedge clk);
        driveIdle();
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
